// File: rtl/axis_matrix_input.sv
// ---------------------------------------------------------------------------
// axis_matrix_input
// Stream-to-vector deserializer for the matrix-multiplication datapath.
// Accepts signed BITWIDTH-bit words on a valid/ready slave stream and packs
// MATSIZE of them into one parallel row. A completed row is held stable until
// the consumer acknowledges it.
//
// Optional feature macro: AXIIN_TLAST_CHECK_EN
//   defined   : s_last is checked on every beat; an early s_last closes the
//               row short, a missing s_last on the final beat flags err.
//   undefined : s_last ignored, err tied low, rows are exactly MATSIZE beats.
//
// Ports
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   start     in   one-cycle request to begin receiving a row
//   s_data    in   incoming signed word
//   s_valid   in   s_data valid
//   s_last    in   final word of a row marker
//   s_ready   out  word accepted this cycle when s_valid (registered)
//   data_out  out  packed row, word k = k-th accepted word (registered)
//   out_valid out  data_out holds a complete row (registered)
//   out_ack   in   consumer has taken data_out
//   count     out  words accepted in current row (registered)
//   err       out  sticky framing error (registered)
// ---------------------------------------------------------------------------
module axis_matrix_input #(
   parameter int unsigned BITWIDTH = 32,
   parameter int unsigned MATSIZE  = 16
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   input  logic                                      start,
   input  logic signed [BITWIDTH-1:0]                s_data,
   input  logic                                      s_valid,
   input  logic                                      s_last,
   output logic                                      s_ready,
   output logic signed [MATSIZE-1:0][BITWIDTH-1:0]   data_out,
   output logic                                      out_valid,
   input  logic                                      out_ack,
   output logic [7:0]                                count,
   output logic                                      err
);

   localparam int unsigned CW       = 8;
   localparam logic [CW-1:0] LAST_IDX = CW'(MATSIZE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t                                   r_state;
   state_t                                   w_state_nxt;

   logic                                     r_s_ready;
   logic                                     r_out_valid;
   logic [CW-1:0]                            r_count;
   logic                                     r_err;
   logic signed [MATSIZE-1:0][BITWIDTH-1:0]  r_data;

   logic                                     w_s_ready_nxt;
   logic                                     w_out_valid_nxt;
   logic [CW-1:0]                            w_count_nxt;
   logic                                     w_err_nxt;
   logic                                     w_clear;
   logic                                     w_wr_en;

   logic                                     w_beat;
   logic                                     w_at_last;
   logic                                     w_early_last;
   logic                                     w_last_err;
   logic                                     w_close;

   assign w_beat    = s_valid && r_s_ready;
   assign w_at_last = (r_count == LAST_IDX);

`ifdef AXIIN_TLAST_CHECK_EN
   // Early s_last closes the row short; missing s_last on the last slot only flags.
   assign w_early_last = s_last && !w_at_last;
   assign w_last_err   = (s_last && !w_at_last) || (!s_last && w_at_last);
`else
   logic w_unused_s_last;
   assign w_unused_s_last = s_last;
   assign w_early_last    = 1'b0;
   assign w_last_err      = 1'b0;
`endif

   assign w_close = w_at_last || w_early_last;

   // State register and registered outputs / row storage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_s_ready   <= 1'b0;
         r_out_valid <= 1'b0;
         r_count     <= '0;
         r_err       <= 1'b0;
         r_data      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_s_ready   <= w_s_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_count     <= w_count_nxt;
         r_err       <= w_err_nxt;
         if (w_clear) begin
            r_data <= '0;
         end else if (w_wr_en) begin
            for (int k = 0; k < int'(MATSIZE); k++) begin
               if (r_count == CW'(k)) begin
                  r_data[k] <= s_data;
               end
            end
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            if (w_beat && w_close) begin
               w_state_nxt = FULL;
            end
         end
         FULL: begin
            if (out_ack) begin
               w_state_nxt = start ? FILL : IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      w_s_ready_nxt   = r_s_ready;
      w_out_valid_nxt = r_out_valid;
      w_count_nxt     = r_count;
      w_err_nxt       = r_err;
      w_clear         = 1'b0;
      w_wr_en         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_s_ready_nxt = 1'b1;
               w_count_nxt   = '0;
               w_err_nxt     = 1'b0;
               w_clear       = 1'b1;
            end
         end
         FILL: begin
            if (w_beat) begin
               w_wr_en     = 1'b1;
               w_count_nxt = r_count + CW'(1);
               if (w_last_err) begin
                  w_err_nxt = 1'b1;
               end
               // Drop ready on the closing edge so no extra word is taken
               if (w_close) begin
                  w_s_ready_nxt   = 1'b0;
                  w_out_valid_nxt = 1'b1;
               end
            end
         end
         FULL: begin
            if (out_ack) begin
               w_out_valid_nxt = 1'b0;
               w_count_nxt     = '0;
               // Back-to-back row: reopen the stream on the same edge
               if (start) begin
                  w_s_ready_nxt = 1'b1;
                  w_err_nxt     = 1'b0;
                  w_clear       = 1'b1;
               end
            end
         end
         default: begin
            w_s_ready_nxt   = 1'b0;
            w_out_valid_nxt = 1'b0;
            w_count_nxt     = '0;
         end
      endcase
   end

   assign s_ready   = r_s_ready;
   assign out_valid = r_out_valid;
   assign count     = r_count;
   assign err       = r_err;
   assign data_out  = r_data;

endmodule
